instruction_fetch: RTL

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch_if.sv | 23 ++
 rtl/instruction_fetch.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_if.sv
// -----------------------------------------------------------------------------
// instruction_fetch_if
//   Instruction-memory bus between the fetch stage and the instruction memory.
//   The fetch stage presents an address and the memory returns the word
//   combinationally in the same cycle.
//
//   Signals:
//     mem_address  fetch -> memory   instruction-memory address (= PC)
//     mem_data     memory -> fetch   10-bit instruction word at mem_address
//
//   Modports:
//     master  fetch-stage side (drives the address)
//     slave   memory side (drives the data)
// -----------------------------------------------------------------------------
interface instruction_fetch_if #(
  parameter int ADDR_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [9:0]            mem_data;

  modport master (output mem_address, input  mem_data);
  modport slave  (input  mem_address, output mem_data);
endinterface

// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
//   Single-stage instruction fetch with relative branch, absolute jump, stall,
//   and a halt/resume mechanism. The word read from memory is registered into
//   the Instruction output one cycle after its address is presented; a
//   redirect flushes the wrong-path word and costs one bubble cycle.
//
//   Ports:
//     i_clk               clock, all state updates on the rising edge
//     i_reset             synchronous active-high reset
//     i_stall             hold all fetch state this cycle
//     i_branch_taken      relative redirect for the word on o_instruction
//     i_branch_offset     6-bit two's-complement branch displacement
//     i_jump_taken        absolute redirect for the word on o_instruction
//     i_jump_target       absolute jump address
//     i_resume            leave the HALTED state
//     imem                instruction-memory bus (master side)
//     o_instruction       registered instruction word for decode
//     o_instruction_pc    address o_instruction was fetched from
//     o_instruction_valid o_instruction holds a real, non-flushed word
//     o_halted            fetch is in the HALTED state
// -----------------------------------------------------------------------------
module instruction_fetch #(
  parameter int                    ADDR_WIDTH  = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
  parameter logic [3:0]            HALT_OPCODE = 4'b1111
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_stall,
  input  logic                  i_branch_taken,
  input  logic [5:0]            i_branch_offset,
  input  logic                  i_jump_taken,
  input  logic [ADDR_WIDTH-1:0] i_jump_target,
  input  logic                  i_resume,
  instruction_fetch_if.master   imem,
  output logic [9:0]            o_instruction,
  output logic [ADDR_WIDTH-1:0] o_instruction_pc,
  output logic                  o_instruction_valid,
  output logic                  o_halted
);

  typedef enum logic {
    ST_RUN,
    ST_HALTED
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [9:0]            r_instr;
  logic [ADDR_WIDTH-1:0] r_instr_pc;
  logic                  r_valid;

  state_t                w_state_next;
  logic [ADDR_WIDTH-1:0] w_pc_next;
  logic [9:0]            w_instr_next;
  logic [ADDR_WIDTH-1:0] w_instr_pc_next;
  logic                  w_valid_next;

  logic [ADDR_WIDTH-1:0] w_pc_inc;
  logic [ADDR_WIDTH-1:0] w_branch_offset_ext;
  logic [ADDR_WIDTH-1:0] w_branch_target;
  logic                  w_is_halt;

  // Sign-extend the displacement; the sum wraps modulo 2^ADDR_WIDTH.
  assign w_branch_offset_ext = ADDR_WIDTH'($signed(i_branch_offset));
  assign w_branch_target     = r_instr_pc + ADDR_WIDTH'(1) + w_branch_offset_ext;
  assign w_pc_inc            = r_pc + ADDR_WIDTH'(1);
  assign w_is_halt           = (imem.mem_data[9:6] == HALT_OPCODE);

  // Next-state and datapath selection.
  always_comb begin
    // NOTE: every target gets a hold default first so no path infers a latch.
    w_state_next    = r_state;
    w_pc_next       = r_pc;
    w_instr_next    = r_instr;
    w_instr_pc_next = r_instr_pc;
    w_valid_next    = r_valid;

    unique case (r_state)
      ST_RUN: begin
        // Redirects refer to the word on o_instruction, so they only count
        // when that word is real; a flushed or empty slot ignores them.
        if (i_jump_taken && r_valid) begin
          w_pc_next    = i_jump_target;
          w_valid_next = 1'b0;
        end else if (i_branch_taken && r_valid) begin
          w_pc_next    = w_branch_target;
          w_valid_next = 1'b0;
        end else if (!i_stall) begin
          w_instr_next    = imem.mem_data;
          w_instr_pc_next = r_pc;
          w_valid_next    = 1'b1;
          if (w_is_halt) begin
            // PC stays on the halt word; resume steps past it.
            w_state_next = ST_HALTED;
          end else begin
            w_pc_next = w_pc_inc;
          end
        end
      end

      ST_HALTED: begin
        // The halt word was presented on the entry edge; drop it afterwards.
        w_valid_next = 1'b0;
        if (i_resume) begin
          w_state_next = ST_RUN;
          w_pc_next    = w_pc_inc;
        end
      end

      default: begin
        w_state_next = ST_RUN;
      end
    endcase
  end

  // State register; reset overrides everything, including redirects.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from values sampled before the edge.
    if (i_reset) begin
      r_state    <= ST_RUN;
      r_pc       <= RESET_PC;
      r_instr    <= '0;
      r_instr_pc <= '0;
      r_valid    <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_pc       <= w_pc_next;
      r_instr    <= w_instr_next;
      r_instr_pc <= w_instr_pc_next;
      r_valid    <= w_valid_next;
    end
  end

  assign imem.mem_address    = r_pc;
  assign o_instruction       = r_instr;
  assign o_instruction_pc    = r_instr_pc;
  assign o_instruction_valid = r_valid;
  assign o_halted            = (r_state == ST_HALTED);

endmodule
